// File: rtl/maze_pkg.sv
// maze_pkg: maze geometry, tile codes, direction encoding and arbiter FSM states
// shared by the maze query arbiter and the mover modules.
package maze_pkg;

   localparam int MAZE_W     = 28;
   localparam int MAZE_H     = 36;
   localparam int TUNNEL_ROW = 19;

   localparam logic [1:0] TILE_PATH = 2'd0;
   localparam logic [1:0] TILE_WALL = 2'd1;
   localparam logic [1:0] TILE_DOOR = 2'd2;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} stateT;

   // Code 3 is an alternate path tile, so only walls and doors need special handling.
   function automatic logic tilePass(logic [1:0] code, logic doorOk);
      return (code == TILE_WALL) ? 1'b0 : (code == TILE_DOOR) ? doorOk : 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap;
// returns one-hot grant, its index and a valid flag.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid && req[(int'(ptr) + i) % N]) begin
            grant[(int'(ptr) + i) % N] = 1'b1;
            idx   = IW'((int'(ptr) + i) % N);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/maze_query_arbiter.sv
// maze_query_arbiter: shares the maze tile ROM among the movers; per grant it reads the
// four neighbour tiles (U,R,D,L) and returns a registered can-move nibble with a done pulse.
module maze_query_arbiter #(
   parameter int N_REQ      = 5,
   parameter int MAZE_W     = maze_pkg::MAZE_W,
   parameter int MAZE_H     = maze_pkg::MAZE_H,
   parameter int TUNNEL_ROW = maze_pkg::TUNNEL_ROW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [6*N_REQ-1:0]   tile_x,
   input  logic [6*N_REQ-1:0]   tile_y,
   input  logic [N_REQ-1:0]     door_ok,
   output logic [9:0]           rom_addr,
   input  logic [1:0]           rom_data,
   output logic [N_REQ-1:0]     done,
   output logic [4*N_REQ-1:0]   can_move,
   output logic                 busy
);
   import maze_pkg::*;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic signed [6:0] XMAX = 7'(MAZE_W - 1);
   localparam logic signed [6:0] YMAX = 7'(MAZE_H - 1);

   stateT state, stateNext;
   logic [IW-1:0] ptr, idx, grantIdx;
   logic [N_REQ-1:0] grantOh;
   logic grantAny;
   logic [5:0] curX, curY;
   logic doorOk;
   logic [1:0] k, pendK;
   logic pend, pendRead;
   logic [3:0] res, resNext;
   logic signed [6:0] nx, ny, wx;
   logic inMaze, onTunnel, nbValid;
   logic [9:0] nbAddr;

   rr_arbiter #(.N(N_REQ), .IW(IW)) arb (
      .req(req),
      .ptr(ptr),
      .grant(grantOh),
      .idx(grantIdx),
      .valid(grantAny)
   );

   assign busy = (state != IDLE);

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    stateNext = grantAny ? ISSUE : IDLE;
         ISSUE:   stateNext = (k == DIR_LEFT) ? DRAIN : ISSUE;
         DRAIN:   stateNext = RESP;
         default: stateNext = IDLE;
      endcase
   end

   // Neighbour for slot k; x wraps only on the tunnel row, out-of-maze tiles block all.
   always_comb begin
      nx       = $signed({1'b0, curX}) + ((k == DIR_RIGHT) ? 7'sd1 : (k == DIR_LEFT) ? -7'sd1 : 7'sd0);
      ny       = $signed({1'b0, curY}) + ((k == DIR_DOWN) ? 7'sd1 : (k == DIR_UP) ? -7'sd1 : 7'sd0);
      inMaze   = (curX < 6'(MAZE_W)) && (curY < 6'(MAZE_H));
      onTunnel = (curY == 6'(TUNNEL_ROW));
      wx       = nx[6] ? XMAX : (nx > XMAX) ? 7'sd0 : nx;
      nbValid  = inMaze && !ny[6] && (ny <= YMAX) && (onTunnel || (!nx[6] && (nx <= XMAX)));
      nbAddr   = 10'(ny) * 10'(MAZE_W) + 10'(wx);
      rom_addr = (state == ISSUE && nbValid) ? nbAddr : '0;
   end

   // ROM data arrives one cycle after its address, so each slot resolves a cycle late.
   always_comb begin
      resNext = res;
      if (pend) resNext[pendK] = pendRead & tilePass(rom_data, doorOk);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         idx      <= '0;
         curX     <= '0;
         curY     <= '0;
         doorOk   <= 1'b0;
         k        <= '0;
         pend     <= 1'b0;
         pendK    <= '0;
         pendRead <= 1'b0;
         res      <= '0;
         done     <= '0;
         can_move <= '0;
      end else begin
         state    <= stateNext;
         done     <= '0;
         pend     <= (state == ISSUE);
         pendK    <= k;
         pendRead <= nbValid;
         res      <= resNext;
         if (state == IDLE && grantAny) begin
            idx    <= grantIdx;
            curX   <= tile_x[6*grantIdx +: 6];
            curY   <= tile_y[6*grantIdx +: 6];
            doorOk <= |(door_ok & grantOh);
            res    <= '0;
         end
         if (state == ISSUE) k <= k + 2'd1;
         if (state == DRAIN) begin
            can_move[4*idx +: 4] <= resNext;
            done                 <= N_REQ'(1) << idx;
         end
         if (state == RESP) ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_maze_query_arbiter.sv
// tb_maze_query_arbiter: directed vector table plus hand-written sequences for
// fairness, mid-transaction request drop and mid-transaction reset.
module tb_maze_query_arbiter;

   localparam int N = 5;

   typedef struct {
      int who;
      int x;
      int y;
      bit door;
      int aU;
      int aR;
      int aD;
      int aL;
      logic [7:0] codes;
      logic [3:0] exp;
   } vecT;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] doorOk = '0;
   logic [6*N-1:0] tileX = '0;
   logic [6*N-1:0] tileY = '0;
   logic [9:0] romAddr;
   logic [1:0] romData = '0;
   logic [N-1:0] done;
   logic [4*N-1:0] canMove;
   logic busy;

   logic [1:0] rom [0:1023];
   logic [4*N-1:0] expCm = '0;
   int errors = 0;
   int checks = 0;
   int reads[$];
   vecT vecs [12];

   always #5 clk = ~clk;

   maze_query_arbiter #(.N_REQ(N)) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .tile_x(tileX),
      .tile_y(tileY),
      .door_ok(doorOk),
      .rom_addr(romAddr),
      .rom_data(romData),
      .done(done),
      .can_move(canMove),
      .busy(busy)
   );

   always @(posedge clk) romData <= rom[romAddr];
   always @(negedge clk) if (busy && romAddr != 10'd0) reads.push_back(int'(romAddr));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic resetDut();
      reset = 1'b1;
      req = '0;
      expCm = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic runVec(input int id, input vecT v, input int dropAt);
      int a[4];
      int expReads[$];
      int lat;
      bit ok;
      a = '{v.aU, v.aR, v.aD, v.aL};
      for (int d = 0; d < 4; d++)
         if (a[d] >= 0) begin
            rom[a[d]] = v.codes[2*d +: 2];
            expReads.push_back(a[d]);
         end
      tileX[6*v.who +: 6] = 6'(v.x);
      tileY[6*v.who +: 6] = 6'(v.y);
      doorOk[v.who] = v.door;
      reads.delete();
      @(negedge clk);
      req[v.who] = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == dropAt) begin
            req[v.who] = 1'b0;
            tileX[6*v.who +: 6] = 6'd20;
            tileY[6*v.who +: 6] = 6'd3;
         end
      end while (done == '0 && lat < 20);
      req[v.who] = 1'b0;
      check($sformatf("v%0d done", id), 32'(done), 32'(1) << v.who);
      check($sformatf("v%0d latency", id), 32'(lat), 32'd6);
      expCm[4*v.who +: 4] = v.exp;
      check($sformatf("v%0d can_move", id), 32'(canMove), 32'(expCm));
      check($sformatf("v%0d read count", id), 32'(reads.size()), 32'(expReads.size()));
      ok = (reads.size() == expReads.size());
      if (ok) for (int i = 0; i < reads.size(); i++) if (reads[i] != expReads[i]) ok = 1'b0;
      check($sformatf("v%0d rom_addr sequence", id), 32'(ok), 32'd1);
      for (int d = 0; d < 4; d++) if (a[d] >= 0) rom[a[d]] = 2'd0;
   endtask

   initial begin
      int n;
      int cyc;
      int lat;
      int evCyc[6];
      logic [N-1:0] evDone[6];
      bit sawDone;

      for (int i = 0; i < 1024; i++) rom[i] = 2'd0;
      // codes packed {L,D,R,U}; expected nibble {L,D,R,U}; -1 = no read expected
      vecs[0]  = '{3, 13, 16, 1'b0, 433, 462, 489, 460, 8'b00_10_01_00, 4'b1001};
      vecs[1]  = '{3, 13, 16, 1'b1, 433, 462, 489, 460, 8'b00_10_01_00, 4'b1101};
      vecs[2]  = '{1,  0, 19, 1'b0, 504, 533, 560, 559, 8'b00_01_00_01, 4'b1010};
      vecs[3]  = '{1,  0, 18, 1'b0, 476, 505, 532,  -1, 8'b00_00_01_00, 4'b0101};
      vecs[4]  = '{2,  5,  0, 1'b0,  -1,   6,  33,   4, 8'b00_10_00_00, 4'b1010};
      vecs[5]  = '{4,  5, 35, 1'b1, 957, 986,  -1, 984, 8'b10_00_01_00, 4'b1001};
      vecs[6]  = '{0, 28,  5, 1'b0,  -1,  -1,  -1,  -1, 8'b00_00_00_00, 4'b0000};
      vecs[7]  = '{0, 27, 19, 1'b0, 531, 532, 587, 558, 8'b01_00_00_01, 4'b0110};
      vecs[8]  = '{2, 27, 10, 1'b0, 279,  -1, 335, 306, 8'b00_00_00_00, 4'b1101};
      vecs[9]  = '{3,  5, 36, 1'b1,  -1,  -1,  -1,  -1, 8'b00_00_00_00, 4'b0000};
      vecs[10] = '{4, 10,  5, 1'b0, 122, 151, 178, 149, 8'b11_01_10_11, 4'b1001};
      vecs[11] = '{2, 13, 16, 1'b1, 433, 462, 489, 460, 8'b00_10_01_00, 4'b1101};

      resetDut();
      check("reset done", 32'(done), 32'd0);
      check("reset can_move", 32'(canMove), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset rom_addr", 32'(romAddr), 32'd0);

      for (int i = 0; i < 11; i++) runVec(i, vecs[i], 0);
      // request dropped and tile moved two cycles after grant
      runVec(11, vecs[11], 2);

      // all requesters held high from reset
      resetDut();
      for (int i = 0; i < N; i++) begin
         tileX[6*i +: 6] = 6'd10;
         tileY[6*i +: 6] = 6'd5;
      end
      doorOk = '0;
      @(negedge clk);
      req = '1;
      n = 0;
      cyc = 0;
      while (n < 6 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (done != '0) begin
            evCyc[n] = cyc;
            evDone[n] = done;
            n++;
         end
      end
      req = '0;
      check("fair done count", 32'(n), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("fair order %0d", i), 32'(evDone[i]), 32'(1) << (i % N));
         check($sformatf("fair cycle %0d", i), 32'(evCyc[i]), 32'(6 + 7*i));
      end
      check("fair can_move", 32'(canMove), 32'h000F_FFFF);

      // reset three cycles after grant
      resetDut();
      @(negedge clk);
      req[3] = 1'b1;
      sawDone = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done != '0) sawDone = 1'b1;
      end
      reset = 1'b1;
      req = '0;
      @(negedge clk);
      if (done != '0) sawDone = 1'b1;
      check("midreset no done", 32'(sawDone), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset can_move", 32'(canMove), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      req = 5'b10001;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done == '0 && lat < 20);
      req = '0;
      check("midreset pointer grant", 32'(done), 32'd1);
      check("midreset latency", 32'(lat), 32'd6);
      check("midreset result", 32'(canMove), 32'h0000_000F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
